// File: rtl/l2_tag_array_nway_if.sv
// rtl/l2_tag_array_nway_if.sv - request/response bundle between the L2 controller and the tag array
interface l2_tag_array_nway_if #(
   parameter int WAYS  = 4,
   parameter int IDX_W = 9,
   parameter int TAG_W = 18
);
   localparam int WAY_W = $clog2(WAYS);

   logic             init_busy;
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_op;
   logic [IDX_W-1:0] req_index;
   logic [TAG_W-1:0] req_tag;
   logic [WAY_W-1:0] req_way;
   logic             req_dirty;
   logic             resp_valid;
   logic             resp_hit;
   logic [WAY_W-1:0] resp_hit_way;
   logic [WAY_W-1:0] resp_victim_way;
   logic             resp_victim_valid;
   logic             resp_victim_dirty;
   logic [TAG_W-1:0] resp_victim_tag;
   logic             wr_done;

   modport master (
      input  init_busy, req_ready, resp_valid, resp_hit, resp_hit_way, resp_victim_way,
             resp_victim_valid, resp_victim_dirty, resp_victim_tag, wr_done,
      output req_valid, req_op, req_index, req_tag, req_way, req_dirty
   );

   modport slave (
      output init_busy, req_ready, resp_valid, resp_hit, resp_hit_way, resp_victim_way,
             resp_victim_valid, resp_victim_dirty, resp_victim_tag, wr_done,
      input  req_valid, req_op, req_index, req_tag, req_way, req_dirty
   );
endinterface

// File: rtl/l2_tag_array_nway.sv
// rtl/l2_tag_array_nway.sv - N-way set-associative tag/valid/dirty/tree-PLRU store with post-reset clear sweep
module l2_tag_array_nway #(
   parameter int WAYS  = 4,
   parameter int IDX_W = 9,
   parameter int TAG_W = 18
) (
   input logic clk,
   input logic rst,
   l2_tag_array_nway_if.slave bus
);
   localparam int WAY_W = $clog2(WAYS);
   localparam int SETS  = 2**IDX_W;
   localparam logic [1:0] OP_LOOKUP = 2'b00;
   localparam logic [1:0] OP_FILL   = 2'b01;
   localparam logic [1:0] OP_INVAL  = 2'b10;

   logic [TAG_W-1:0] tag_q   [SETS][WAYS];
   logic [WAYS-1:0]  valid_q [SETS];
   logic [WAYS-1:0]  dirty_q [SETS];
   logic [WAYS-2:0]  plru_q  [SETS];

   logic             init_busy;
   logic [IDX_W-1:0] sweep_idx;

   logic             accept;
   logic [WAYS-1:0]  set_valid;
   logic [WAYS-1:0]  set_dirty;
   logic [WAYS-2:0]  set_plru;
   logic [WAYS-2:0]  plru_next;
   logic             hit;
   logic             any_invalid;
   logic [WAY_W-1:0] hit_way;
   logic [WAY_W-1:0] inv_way;
   logic [WAY_W-1:0] walk_way;
   logic [WAY_W-1:0] victim_way;
   logic [WAY_W-1:0] touch_way;

   assign bus.req_ready = !init_busy;
   assign bus.init_busy = init_busy;

   // All lookups read state committed at the previous edge, so back-to-back requests need no bypass.
   always_comb begin
      int   node;
      logic b;
      accept    = bus.req_valid && !init_busy;
      set_valid = valid_q[bus.req_index];
      set_dirty = dirty_q[bus.req_index];
      set_plru  = plru_q[bus.req_index];

      hit         = 1'b0;
      hit_way     = '0;
      any_invalid = 1'b0;
      inv_way     = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (set_valid[w] && (tag_q[bus.req_index][w] == bus.req_tag)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!set_valid[w]) begin
            any_invalid = 1'b1;
            inv_way     = WAY_W'(w);
         end
      end

      walk_way = '0;
      node     = 0;
      for (int lvl = 0; lvl < WAY_W; lvl++) begin
         b = 1'b0;
         for (int n = 0; n < WAYS - 1; n++) begin
            if (n == node) b = set_plru[n];
         end
         walk_way[WAY_W-1-lvl] = b;
         node = 2 * node + 1 + (b ? 1 : 0);
      end
      victim_way = any_invalid ? inv_way : walk_way;

      // Each node on the accessed way's path is pointed at the opposite half.
      touch_way = (bus.req_op == OP_FILL) ? bus.req_way : hit_way;
      plru_next = set_plru;
      node      = 0;
      for (int lvl = 0; lvl < WAY_W; lvl++) begin
         b = touch_way[WAY_W-1-lvl];
         for (int n = 0; n < WAYS - 1; n++) begin
            if (n == node) plru_next[n] = !b;
         end
         node = 2 * node + 1 + (b ? 1 : 0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         init_busy             <= 1'b1;
         sweep_idx             <= '0;
         bus.resp_valid        <= 1'b0;
         bus.resp_hit          <= 1'b0;
         bus.resp_hit_way      <= '0;
         bus.resp_victim_way   <= '0;
         bus.resp_victim_valid <= 1'b0;
         bus.resp_victim_dirty <= 1'b0;
         bus.resp_victim_tag   <= '0;
         bus.wr_done           <= 1'b0;
      end else begin
         bus.resp_valid <= 1'b0;
         bus.wr_done    <= 1'b0;
         if (init_busy) begin
            valid_q[sweep_idx] <= '0;
            dirty_q[sweep_idx] <= '0;
            plru_q[sweep_idx]  <= '0;
            sweep_idx          <= sweep_idx + 1'b1;
            if (&sweep_idx) init_busy <= 1'b0;
         end else if (accept) begin
            case (bus.req_op)
               OP_LOOKUP: begin
                  if (hit) begin
                     plru_q[bus.req_index] <= plru_next;
                     if (bus.req_dirty) dirty_q[bus.req_index][hit_way] <= 1'b1;
                  end
                  bus.resp_valid        <= 1'b1;
                  bus.resp_hit          <= hit;
                  bus.resp_hit_way      <= hit_way;
                  bus.resp_victim_way   <= victim_way;
                  bus.resp_victim_valid <= set_valid[victim_way];
                  bus.resp_victim_dirty <= set_dirty[victim_way];
                  bus.resp_victim_tag   <= tag_q[bus.req_index][victim_way];
               end
               OP_FILL: begin
                  tag_q[bus.req_index][bus.req_way]   <= bus.req_tag;
                  valid_q[bus.req_index][bus.req_way] <= 1'b1;
                  dirty_q[bus.req_index][bus.req_way] <= bus.req_dirty;
                  plru_q[bus.req_index]               <= plru_next;
                  bus.wr_done                         <= 1'b1;
               end
               OP_INVAL: begin
                  valid_q[bus.req_index][bus.req_way] <= 1'b0;
                  dirty_q[bus.req_index][bus.req_way] <= 1'b0;
                  bus.wr_done                         <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_l2_tag_array_nway.sv
// tb/tb_l2_tag_array_nway.sv - self-checking bench for l2_tag_array_nway (4-way/512-set and 8-way/16-set instances)
module tb_l2_tag_array_nway;
   localparam int AW = 4, AI = 9, BW = 8, BI = 4, TW = 18;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   l2_tag_array_nway_if #(.WAYS(AW), .IDX_W(AI), .TAG_W(TW)) bus_a ();
   l2_tag_array_nway_if #(.WAYS(BW), .IDX_W(BI), .TAG_W(TW)) bus_b ();

   l2_tag_array_nway #(.WAYS(AW), .IDX_W(AI), .TAG_W(TW)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   l2_tag_array_nway #(.WAYS(BW), .IDX_W(BI), .TAG_W(TW)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   // Reference model: replacement derived from per-way last-access times rather than tree bits.
   bit          m_valid [2][512][8];
   bit          m_dirty [2][512][8];
   logic [17:0] m_tag   [2][512][8];
   int unsigned m_ts    [2][512][8];
   int unsigned stamp;

   bit          e_hit    [2];
   int          e_hw     [2];
   int          e_vway   [2];
   bit          e_vvalid [2];
   bit          e_vdirty [2];
   logic [17:0] e_vtag   [2];

   int passed = 0;
   int total  = 0;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int s = 0; s < 512; s++) begin
            for (int w = 0; w < 8; w++) begin
               m_valid[d][s][w] = 0;
               m_dirty[d][s][w] = 0;
               m_tag[d][s][w]   = '0;
               m_ts[d][s][w]    = 0;
            end
         end
         e_hit[d] = 0; e_hw[d] = 0; e_vway[d] = 0;
         e_vvalid[d] = 0; e_vdirty[d] = 0; e_vtag[d] = '0;
      end
      stamp = 0;
   endtask

   function automatic int m_victim(input int d, input int s, input int ways);
      int lo, size, half;
      int unsigned ml, mu;
      for (int w = 0; w < ways; w++) if (!m_valid[d][s][w]) return w;
      lo = 0;
      size = ways;
      while (size > 1) begin
         half = size / 2;
         ml = 0;
         mu = 0;
         for (int i = 0; i < half; i++) begin
            if (m_ts[d][s][lo+i] > ml) ml = m_ts[d][s][lo+i];
            if (m_ts[d][s][lo+half+i] > mu) mu = m_ts[d][s][lo+half+i];
         end
         if (ml > mu) lo = lo + half;
         size = half;
      end
      return lo;
   endfunction

   task automatic step(input int d, input logic [1:0] op, input int idx, input logic [17:0] tag,
                       input int way, input bit dirty, input string name);
      int ways;
      logic [31:0] o_rv, o_wd, o_hit, o_hw, o_vw, o_vv, o_vd, o_vt;
      ways = (d == 0) ? AW : BW;
      if (d == 0) begin
         bus_a.req_valid = 1'b1; bus_a.req_op = op; bus_a.req_index = AI'(idx);
         bus_a.req_tag = tag; bus_a.req_way = 2'(way); bus_a.req_dirty = dirty;
      end else begin
         bus_b.req_valid = 1'b1; bus_b.req_op = op; bus_b.req_index = BI'(idx);
         bus_b.req_tag = tag; bus_b.req_way = 3'(way); bus_b.req_dirty = dirty;
      end
      if (op == 2'b00) begin
         e_hit[d] = 0;
         e_hw[d]  = 0;
         for (int w = ways - 1; w >= 0; w--) begin
            if (m_valid[d][idx][w] && m_tag[d][idx][w] == tag) begin
               e_hit[d] = 1;
               e_hw[d]  = w;
            end
         end
         e_vway[d]   = m_victim(d, idx, ways);
         e_vvalid[d] = m_valid[d][idx][e_vway[d]];
         e_vdirty[d] = m_dirty[d][idx][e_vway[d]];
         e_vtag[d]   = m_tag[d][idx][e_vway[d]];
         if (e_hit[d]) begin
            stamp++;
            m_ts[d][idx][e_hw[d]] = stamp;
            if (dirty) m_dirty[d][idx][e_hw[d]] = 1;
         end
      end else if (op == 2'b01) begin
         m_tag[d][idx][way]   = tag;
         m_valid[d][idx][way] = 1;
         m_dirty[d][idx][way] = dirty;
         stamp++;
         m_ts[d][idx][way] = stamp;
      end else if (op == 2'b10) begin
         m_valid[d][idx][way] = 0;
         m_dirty[d][idx][way] = 0;
      end
      @(posedge clk);
      #1;
      if (d == 0) begin
         bus_a.req_valid = 1'b0;
         o_rv = 32'(bus_a.resp_valid); o_wd = 32'(bus_a.wr_done); o_hit = 32'(bus_a.resp_hit);
         o_hw = 32'(bus_a.resp_hit_way); o_vw = 32'(bus_a.resp_victim_way);
         o_vv = 32'(bus_a.resp_victim_valid); o_vd = 32'(bus_a.resp_victim_dirty);
         o_vt = 32'(bus_a.resp_victim_tag);
      end else begin
         bus_b.req_valid = 1'b0;
         o_rv = 32'(bus_b.resp_valid); o_wd = 32'(bus_b.wr_done); o_hit = 32'(bus_b.resp_hit);
         o_hw = 32'(bus_b.resp_hit_way); o_vw = 32'(bus_b.resp_victim_way);
         o_vv = 32'(bus_b.resp_victim_valid); o_vd = 32'(bus_b.resp_victim_dirty);
         o_vt = 32'(bus_b.resp_victim_tag);
      end
      chk($sformatf("%s.resp_valid", name), o_rv, 32'(op == 2'b00));
      chk($sformatf("%s.wr_done", name), o_wd, 32'(op == 2'b01 || op == 2'b10));
      chk($sformatf("%s.hit", name), o_hit, 32'(e_hit[d]));
      if (e_hit[d]) chk($sformatf("%s.hit_way", name), o_hw, 32'(e_hw[d]));
      chk($sformatf("%s.victim_way", name), o_vw, 32'(e_vway[d]));
      chk($sformatf("%s.victim_valid", name), o_vv, 32'(e_vvalid[d]));
      chk($sformatf("%s.victim_dirty", name), o_vd, 32'(e_vdirty[d]));
      if (e_vvalid[d]) chk($sformatf("%s.victim_tag", name), o_vt, 32'(e_vtag[d]));
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, rv_seen, mask, v, k, r;
      int idx_pool [4];
      idx_pool = '{0, 1, 2, 511};

      bus_a.req_valid = 0; bus_a.req_op = 0; bus_a.req_index = '0; bus_a.req_tag = '0;
      bus_a.req_way = '0; bus_a.req_dirty = 0;
      bus_b.req_valid = 0; bus_b.req_op = 0; bus_b.req_index = '0; bus_b.req_tag = '0;
      bus_b.req_way = '0; bus_b.req_dirty = 0;
      model_reset();

      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.init_busy", 32'(bus_a.init_busy), 32'd1);
      chk("rst.req_ready", 32'(bus_a.req_ready), 32'd0);
      chk("rst.resp_valid", 32'(bus_a.resp_valid), 32'd0);
      chk("rst.wr_done", 32'(bus_a.wr_done), 32'd0);
      chk("rst.resp_hit", 32'(bus_a.resp_hit), 32'd0);
      chk("rst.victim_way", 32'(bus_a.resp_victim_way), 32'd0);
      chk("rst.victim_valid", 32'(bus_a.resp_victim_valid), 32'd0);
      chk("rst.victim_tag", 32'(bus_a.resp_victim_tag), 32'd0);

      // T1: sweep interrupted at cycle 200, then a full uninterrupted sweep with req_valid held high
      rst = 1'b0;
      bus_a.req_valid = 1'b1;
      repeat (199) @(posedge clk);
      #1;
      chk("t1.busy_at_200", 32'(bus_a.init_busy), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      n = 0;
      rv_seen = 0;
      while (bus_a.req_ready === 1'b0 && n < 2000) begin
         if (bus_a.init_busy !== 1'b1 || bus_a.resp_valid !== 1'b0) rv_seen++;
         n++;
         @(posedge clk);
         #1;
      end
      chk("t1.busy_cycles", 32'(n), 32'd512);
      chk("t1.no_resp_while_busy", 32'(rv_seen), 32'd0);
      chk("t1.init_busy_low", 32'(bus_a.init_busy), 32'd0);
      chk("t1.no_resp_before_accept", 32'(bus_a.resp_valid), 32'd0);
      @(posedge clk);
      #1;
      bus_a.req_valid = 1'b0;
      chk("t1.first_accept_resp", 32'(bus_a.resp_valid), 32'd1);
      chk("t1.b_idle", 32'(bus_b.init_busy), 32'd0);
      model_reset();

      // T2: fresh set
      step(0, 2'b00, 5, 18'h1234, 0, 0, "t2_lookup0");
      chk("t2.miss", 32'(bus_a.resp_hit), 32'd0);
      chk("t2.victim0", 32'(bus_a.resp_victim_way), 32'd0);
      chk("t2.victim_invalid", 32'(bus_a.resp_victim_valid), 32'd0);
      step(0, 2'b01, 5, 18'h1234, 2, 0, "t2_fill");
      step(0, 2'b00, 5, 18'h1234, 0, 0, "t2_lookup1");
      chk("t2.hit", 32'(bus_a.resp_hit), 32'd1);
      chk("t2.hit_way", 32'(bus_a.resp_hit_way), 32'd2);

      // T3: PLRU order on set 7
      for (int w = 0; w < 4; w++) step(0, 2'b01, 7, 18'(32'h100 + w), w, 0, "t3_fill");
      step(0, 2'b00, 7, 18'h3ff, 0, 0, "t3_miss0");
      chk("t3.victim_after_fills", 32'(bus_a.resp_victim_way), 32'd0);
      step(0, 2'b00, 7, 18'h100, 0, 0, "t3_hit0");
      step(0, 2'b00, 7, 18'h3ff, 0, 0, "t3_miss1");
      chk("t3.victim_after_hit0", 32'(bus_a.resp_victim_way), 32'd2);

      // T4: store hit marks dirty, victim reports it; INVAL frees the way
      for (int w = 0; w < 4; w++) step(0, 2'b01, 9, 18'(32'h200 + w), w, 0, "t4_fill");
      step(0, 2'b00, 9, 18'h201, 0, 1, "t4_store");
      step(0, 2'b00, 9, 18'h200, 0, 0, "t4_hit0");
      step(0, 2'b00, 9, 18'h202, 0, 0, "t4_hit2");
      step(0, 2'b00, 9, 18'h203, 0, 0, "t4_hit3");
      step(0, 2'b00, 9, 18'h2ff, 0, 0, "t4_miss");
      chk("t4.victim_way", 32'(bus_a.resp_victim_way), 32'd1);
      chk("t4.victim_dirty", 32'(bus_a.resp_victim_dirty), 32'd1);
      chk("t4.victim_tag", 32'(bus_a.resp_victim_tag), 32'h201);
      step(0, 2'b10, 9, 18'h0, 1, 0, "t4_inval");
      step(0, 2'b00, 9, 18'h2ff, 0, 0, "t4_miss2");
      chk("t4.inval_victim_way", 32'(bus_a.resp_victim_way), 32'd1);
      chk("t4.inval_victim_valid", 32'(bus_a.resp_victim_valid), 32'd0);
      chk("t4.inval_victim_dirty", 32'(bus_a.resp_victim_dirty), 32'd0);

      // T5: 8-way instance, miss+fill cycle must visit every way once
      for (int w = 0; w < 8; w++) step(1, 2'b01, 3, 18'(32'h500 + w), w, w[0], "t5_fill");
      mask = 0;
      for (k = 0; k < 8; k++) begin
         step(1, 2'b00, 3, 18'(32'h600 + k), 0, 0, "t5_miss");
         v = int'(bus_b.resp_victim_way);
         mask = mask | (1 << v);
         step(1, 2'b01, 3, 18'(32'h600 + k), v, 0, "t5_refill");
      end
      chk("t5.all_ways_victimised", 32'(mask), 32'hff);
      step(1, 2'b11, 3, 18'h600, 0, 0, "t5_reserved");
      step(0, 2'b11, 5, 18'h1234, 2, 0, "t5_reserved_a");
      step(1, 2'b00, 15, 18'h1, 0, 0, "t5_last_set");

      // Randomised traffic on both instances, including the last set index
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 9);
         step(0, (r < 5) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11,
              idx_pool[$urandom_range(0, 3)], 18'(32'h40 + $urandom_range(0, 5)),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rand_a");
      end
      for (int i = 0; i < 200; i++) begin
         r = $urandom_range(0, 9);
         step(1, (r < 5) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11,
              ($urandom_range(0, 1) == 1) ? 15 : 0, 18'(32'h80 + $urandom_range(0, 9)),
              $urandom_range(0, 7), 1'($urandom_range(0, 1)), "rand_b");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
